mult_sched_rr: RTL

//  Shares one serial shift-add multiplier core among NUM_REQ requesters.

---
 rtl/mult_sched_pkg.sv | 14 +
 rtl/mult_core_serial.sv | 60 ++++++
 rtl/mult_sched_rr.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/mult_sched_pkg.sv
// rtl/mult_sched_pkg.sv - shared encodings and defaults for the multiplier scheduler
package mult_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int DEF_WIDTH   = 4;
    localparam int DEF_NUM_REQ = 4;
    localparam int DONE_CNT_W  = 8;

endpackage

// File: rtl/mult_core_serial.sv
// rtl/mult_core_serial.sv - serial shift-add unsigned multiplier, fixed WIDTH-step latency
module mult_core_serial #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             run_q, run_d;
    logic             done_q, done_d;
    logic [WIDTH:0]   sum;

    always_comb begin
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        done_d = 1'b0;
        // Upper half plus B; the extra ACC bit keeps the carry until the shift.
        sum    = acc_q[2*WIDTH:WIDTH] + {1'b0, b};
        if (start) begin
            acc_d = {{(WIDTH + 1){1'b0}}, a};
            cnt_d = CW'(WIDTH);
            run_d = 1'b1;
        end else if (run_q) begin
            acc_d = acc_q[0] ? ({sum, acc_q[WIDTH-1:0]} >> 1) : (acc_q >> 1);
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    assign done    = done_q;
    assign product = acc_q[2*WIDTH-1:0];

endmodule

// File: rtl/mult_sched_rr.sv
// rtl/mult_sched_rr.sv - round-robin scheduler sharing one serial multiplier among requesters
module mult_sched_rr
    import mult_sched_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [IDW-1:0]           rsp_id,
    output logic [2*WIDTH-1:0]       rsp_product,
    output logic                     busy,
    output logic [DONE_CNT_W-1:0]    done_count
);

    state_t                  state_q, state_d;
    logic [IDW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]          id_q, id_d;
    logic [WIDTH-1:0]        a_q, a_d, b_q, b_d;
    logic                    start_q, start_d;
    logic [IDW-1:0]          rsp_id_q, rsp_id_d;
    logic [2*WIDTH-1:0]      rsp_product_q, rsp_product_d;
    logic [DONE_CNT_W-1:0]   done_count_q, done_count_d;

    logic                    grant_found;
    logic [IDW-1:0]          grant_idx;
    logic [IDW:0]            cand_sum;
    logic [IDW-1:0]          cand;
    logic [WIDTH-1:0]        sel_a, sel_b;
    logic                    core_done;
    logic [2*WIDTH-1:0]      core_product;

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_sum    = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_sum = {1'b0, rr_ptr_q} + (IDW + 1)'(k);
            cand     = (cand_sum >= (IDW + 1)'(NUM_REQ)) ?
                       IDW'(cand_sum - (IDW + 1)'(NUM_REQ)) : IDW'(cand_sum);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        sel_a     = '0;
        sel_b     = '0;
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IDW'(i) == grant_idx) begin
                sel_a        = req_a[i*WIDTH +: WIDTH];
                sel_b        = req_b[i*WIDTH +: WIDTH];
                req_ready[i] = (state_q == ST_IDLE) && grant_found;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        id_d          = id_q;
        a_d           = a_q;
        b_d           = b_q;
        start_d       = 1'b0;
        rsp_id_d      = rsp_id_q;
        rsp_product_d = rsp_product_q;
        done_count_d  = done_count_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_found) begin
                    id_d     = grant_idx;
                    a_d      = sel_a;
                    b_d      = sel_b;
                    rr_ptr_d = (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + IDW'(1);
                    start_d  = 1'b1;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (core_done) begin
                    rsp_id_d      = id_q;
                    rsp_product_d = core_product;
                    state_d       = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    done_count_d = done_count_q + DONE_CNT_W'(1);
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            rr_ptr_q      <= '0;
            id_q          <= '0;
            a_q           <= '0;
            b_q           <= '0;
            start_q       <= 1'b0;
            rsp_id_q      <= '0;
            rsp_product_q <= '0;
            done_count_q  <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            id_q          <= id_d;
            a_q           <= a_d;
            b_q           <= b_d;
            start_q       <= start_d;
            rsp_id_q      <= rsp_id_d;
            rsp_product_q <= rsp_product_d;
            done_count_q  <= done_count_d;
        end
    end

    mult_core_serial #(.WIDTH(WIDTH)) u_core (
        .clk     (clk),
        .reset   (reset),
        .start   (start_q),
        .a       (a_q),
        .b       (b_q),
        .done    (core_done),
        .product (core_product)
    );

    assign rsp_valid   = (state_q == ST_RESP);
    assign busy        = (state_q != ST_IDLE);
    assign rsp_id      = rsp_id_q;
    assign rsp_product = rsp_product_q;
    assign done_count  = done_count_q;

endmodule
